// File: rtl/rom_loader_pkg.sv
// Shared constants for the serial program loader: sync byte, count width, FSM states.
package rom_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'h55;
    localparam int         COUNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    function automatic logic in_frame(input state_e s);
        return s inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// Inter-byte idle watchdog: reloads on clear, counts down while enabled, pulses on expiry.
module rom_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires in the TIMEOUT_CYCLES-th idle cycle; a clear in that cycle suppresses it.
    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && !clr_i && (cnt_q == CW'(1));

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Serial program loader: parses 0x55/count/data/checksum frames from the UART and writes
// big-endian 16-bit words into instruction memory, holding the CPU in reset while loading.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH          = 2**15,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic [7:0]               i_Rx_Data,
    input  logic                     i_Rx_Valid,
    output logic                     o_Rx_Ready,
    output logic                     o_Wr_En,
    output logic [$clog2(DEPTH)-1:0] o_Wr_Addr,
    output logic [WIDTH-1:0]         o_Wr_Data,
    output logic                     o_Cpu_Reset,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Error
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e               state_q, state_d;
    logic [7:0]           hi_q, hi_d;
    logic [7:0]           chk_q, chk_d;
    logic [COUNT_W-1:0]   remain_q, remain_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 error_q, error_d, cpu_rst_q, cpu_rst_d;
    logic                 fire_s, expire_s, tmo_en_s, tmo_clr_s;
    logic [COUNT_W-1:0]   count_s;

    // Memory takes a write every cycle, so the loader never back-pressures.
    assign o_Rx_Ready = 1'b1;
    assign fire_s     = i_Rx_Valid;
    assign tmo_en_s   = in_frame(state_q);
    assign tmo_clr_s  = fire_s || !tmo_en_s;
    assign count_s    = {hi_q, i_Rx_Data};

    rom_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (i_Clk),
        .rst_i   (i_Reset),
        .clr_i   (tmo_clr_s),
        .en_i    (tmo_en_s),
        .expire_o(expire_s)
    );

    // Frame parser next-state and datapath
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        chk_d     = chk_q;
        remain_d  = remain_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (expire_s) begin
            state_d = ST_ERROR;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (fire_s && (i_Rx_Data == LOADER_SYNC)) begin
                        state_d = ST_CNT_HI;
                        chk_d   = 8'h00;
                        addr_d  = '0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CNT_HI: begin
                    if (fire_s) begin
                        hi_d    = i_Rx_Data;
                        chk_d   = chk_q ^ i_Rx_Data;
                        state_d = ST_CNT_LO;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CNT_LO: begin
                    if (fire_s) begin
                        chk_d    = chk_q ^ i_Rx_Data;
                        remain_d = count_s;
                        if (32'(count_s) > DEPTH) begin
                            state_d = ST_ERROR;
                        end else if (count_s == '0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA_HI;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DATA_HI: begin
                    if (fire_s) begin
                        hi_d    = i_Rx_Data;
                        chk_d   = chk_q ^ i_Rx_Data;
                        state_d = ST_DATA_LO;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DATA_LO: begin
                    if (fire_s) begin
                        chk_d     = chk_q ^ i_Rx_Data;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {hi_q, i_Rx_Data};
                        addr_d    = addr_q + AW'(1);
                        remain_d  = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA_HI;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CHECK: begin
                    if (fire_s) begin
                        if (i_Rx_Data == chk_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // ERROR keeps the CPU held until a good frame arrives.
        busy_d    = in_frame(state_d);
        done_d    = (state_d == ST_DONE);
        error_d   = (state_d == ST_ERROR);
        cpu_rst_d = in_frame(state_d) || (state_d == ST_ERROR);
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= 8'h00;
            chk_q     <= 8'h00;
            remain_q  <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            chk_q     <= chk_d;
            remain_q  <= remain_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Error     = error_q;
    assign o_Cpu_Reset = cpu_rst_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: frames are built from the format rules and the
// expected writes/status follow directly from how each frame was constructed.
module tb_rom_loader;

    localparam int unsigned DEPTH = 2**15;
    localparam int unsigned TO    = 100;

    typedef logic [30:0] wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_q[$];
    wr_t        exp_w[$];
    wr_t        got_w[$];

    always #5 clk = ~clk;

    rom_loader #(
        .DEPTH(DEPTH),
        .WIDTH(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Rx_Data(rx_data),
        .i_Rx_Valid(rx_valid),
        .o_Rx_Ready(rx_ready),
        .o_Wr_En(wr_en),
        .o_Wr_Addr(wr_addr),
        .o_Wr_Data(wr_data),
        .o_Cpu_Reset(cpu_rst),
        .o_Busy(busy),
        .o_Done(done),
        .o_Error(err)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) got_w.push_back({wr_addr, wr_data});
    end

    // Appends a frame of n random words (optionally with a corrupted checksum) to tx_q.
    task automatic build_frame(input int n, input bit good);
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  c;
        int          s;
        nn = 16'(n);
        tx_q.push_back(8'h55);
        s = tx_q.size();
        tx_q.push_back(nn[15:8]);
        tx_q.push_back(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
            exp_w.push_back({15'(i), w});
        end
        c = 8'h00;
        for (int i = s; i < tx_q.size(); i++) c = c ^ tx_q[i];
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        tx_q.push_back(c);
    endtask

    task automatic add_noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h55) b = 8'hAA;
            tx_q.push_back(b);
        end
    endtask

    // Streams tx_q starting at a negedge, with up to max_gap idle cycles between bytes.
    task automatic drive(input int max_gap);
        int g;
        for (int i = 0; i < tx_q.size(); i++) begin
            rx_data  = tx_q[i];
            rx_valid = 1'b1;
            @(negedge clk);
            if (max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                rx_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        tx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_ready, wr_en, done, err, cpu_rst, busy} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_held: got %b want 100000", {rx_ready, wr_en, done, err, cpu_rst, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rx_ready, wr_en, done, err, cpu_rst, busy, wr_addr, wr_data} !== {6'b100000, 31'd0}) begin
            n_fail++; $display("FAIL reset_released: got %b/%h/%h", {rx_ready, wr_en, done, err, cpu_rst, busy}, wr_addr, wr_data);
        end
    endtask

    task automatic test_fixed(input logic [7:0] last, input logic [3:0] want, input string nm);
        int base;
        base = got_w.size();
        tx_q = '{8'h55, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, last};
        exp_w = '{{15'd0, 16'h1234}, {15'd1, 16'hABCD}};
        drive(0);
        n_checks++;
        if (got_w.size() - base !== exp_w.size()) begin
            n_fail++; $display("FAIL %s_wr_count: got %0d want %0d", nm, got_w.size() - base, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && base + i < got_w.size(); i++) begin
            n_checks++;
            if (got_w[base + i] !== exp_w[i]) begin
                n_fail++; $display("FAIL %s_wr%0d: got %h want %h", nm, i, got_w[base + i], exp_w[i]);
            end
        end
        n_checks++;
        if ({done, err, cpu_rst, busy} !== want) begin
            n_fail++; $display("FAIL %s_status: got %b want %b", nm, {done, err, cpu_rst, busy}, want);
        end
    endtask

    task automatic test_count_limits();
        int base;
        base = got_w.size();
        tx_q = '{8'h55, 8'h80, 8'h01};
        drive(0);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b0110 || got_w.size() != base) begin
            n_fail++; $display("FAIL oversize: got status %b writes %0d want 0110/0", {done, err, cpu_rst, busy}, got_w.size() - base);
        end
        tx_q = '{8'h55, 8'h80, 8'h00};
        drive(0);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b0011) begin
            n_fail++; $display("FAIL count_eq_depth: got %b want 0011", {done, err, cpu_rst, busy});
        end
        repeat (TO + 1) @(negedge clk);
        base = got_w.size();
        tx_q = '{8'h55, 8'h00, 8'h00, 8'h00};
        drive(0);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b1000 || got_w.size() != base) begin
            n_fail++; $display("FAIL empty: got status %b writes %0d want 1000/0", {done, err, cpu_rst, busy}, got_w.size() - base);
        end
    endtask

    task automatic test_noise_back_to_back();
        int base;
        base = got_w.size();
        add_noise(4);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'h13);
        drive(1);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b1000 || got_w.size() != base) begin
            n_fail++; $display("FAIL noise: got status %b writes %0d want 1000/0", {done, err, cpu_rst, busy}, got_w.size() - base);
        end
        exp_w.delete();
        build_frame(3, 1'b1);
        build_frame(2, 1'b1);
        drive(0);
        n_checks++;
        if (got_w.size() - base !== exp_w.size()) begin
            n_fail++; $display("FAIL b2b_wr_count: got %0d want %0d", got_w.size() - base, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && base + i < got_w.size(); i++) begin
            n_checks++;
            if (got_w[base + i] !== exp_w[i]) begin
                n_fail++; $display("FAIL b2b_wr%0d: got %h want %h", i, got_w[base + i], exp_w[i]);
            end
        end
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_fail++; $display("FAIL b2b_status: got %b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    task automatic test_random_frames();
        int  base;
        int  n;
        bit  good;
        for (int f = 0; f < 8; f++) begin
            exp_w.delete();
            add_noise($urandom_range(0, 3));
            n    = $urandom_range(0, 6);
            good = ($urandom_range(0, 3) != 0);
            build_frame(n, good);
            base = got_w.size();
            drive(3);
            n_checks++;
            if (got_w.size() - base !== exp_w.size()) begin
                n_fail++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", f, got_w.size() - base, exp_w.size());
            end
            for (int i = 0; i < exp_w.size() && base + i < got_w.size(); i++) begin
                n_checks++;
                if (got_w[base + i] !== exp_w[i]) begin
                    n_fail++; $display("FAIL rnd%0d_wr%0d: got %h want %h", f, i, got_w[base + i], exp_w[i]);
                end
            end
            n_checks++;
            if ({done, err, cpu_rst, busy} !== (good ? 4'b1000 : 4'b0110)) begin
                n_fail++; $display("FAIL rnd%0d_status: got %b want %b", f, {done, err, cpu_rst, busy}, good ? 4'b1000 : 4'b0110);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        base = got_w.size();
        tx_q = '{8'h55, 8'h00, 8'h01, 8'h12};
        drive(0);
        repeat (TO - 1) @(negedge clk);
        n_checks++;
        if ({err, busy} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_early: got err/busy %b want 01", {err, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b0110 || got_w.size() != base) begin
            n_fail++; $display("FAIL timeout_fire: got status %b writes %0d want 0110/0", {done, err, cpu_rst, busy}, got_w.size() - base);
        end
        tx_q = '{8'h55, 8'h00, 8'h01, 8'h12};
        drive(0);
        repeat (TO - 1) @(negedge clk);
        rx_data = 8'h34; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        n_checks++;
        if ({err, busy} !== 2'b01) begin
            n_fail++; $display("FAIL timeout_byte_wins: got err/busy %b want 01", {err, busy});
        end
        tx_q = '{8'h27};
        drive(0);
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b1000 || got_w.size() != base + 1) begin
            n_fail++; $display("FAIL timeout_recover: got status %b writes %0d want 1000/1", {done, err, cpu_rst, busy}, got_w.size() - base);
        end else begin
            n_checks++;
            if (got_w[base] !== {15'd0, 16'h1234}) begin
                n_fail++; $display("FAIL timeout_recover_wr: got %h want %h", got_w[base], {15'd0, 16'h1234});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = got_w.size();
        tx_q = '{8'h55, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        drive(0);
        rx_data = 8'hCD; rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1; rx_valid = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, wr_en, done, err, cpu_rst, busy} !== 6'b100000) begin
            n_fail++; $display("FAIL midreset_async: got %b want 100000", {rx_ready, wr_en, done, err, cpu_rst, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (got_w.size() - base !== 1) begin
            n_fail++; $display("FAIL midreset_strobe: got %0d writes want 1", got_w.size() - base);
        end
        exp_w.delete();
        build_frame(4, 1'b1);
        base = got_w.size();
        drive(1);
        n_checks++;
        if (got_w.size() - base !== exp_w.size()) begin
            n_fail++; $display("FAIL midreset_reload_count: got %0d want %0d", got_w.size() - base, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && base + i < got_w.size(); i++) begin
            n_checks++;
            if (got_w[base + i] !== exp_w[i]) begin
                n_fail++; $display("FAIL midreset_reload_wr%0d: got %h want %h", i, got_w[base + i], exp_w[i]);
            end
        end
        n_checks++;
        if ({done, err, cpu_rst, busy} !== 4'b1000) begin
            n_fail++; $display("FAIL midreset_reload_status: got %b want 1000", {done, err, cpu_rst, busy});
        end
    endtask

    initial begin
        test_reset();
        test_fixed(8'h42, 4'b1000, "good");
        test_fixed(8'h43, 4'b0110, "badsum");
        test_count_limits();
        test_noise_back_to_back();
        test_random_frames();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
